demux9bit_1to3_reg: RTL

Registered 1-to-3 demultiplexer for 9-bit control words: accepts one word per cycle on a valid/ready input and steers it, by a 2-bit select, into one of three single-entry output slots, each with its own valid/ready handshake. Sits on the ID side of the pipeline, where a decoded control bundle is distributed to one of three consumers. The fourth select code discards the word and counts the drop. Output latency is one cycle.

---
 rtl/demux_pkg.sv | 26 ++
 rtl/out_slot.sv | 38 +++
 rtl/demux9bit_1to3_reg.sv | 92 +++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared select encodings and decode helper for the 1-to-3 control-word demux.
package demux_pkg;

    localparam int NUM_SLOTS = 3;

    typedef enum logic [1:0] {
        SEL_A    = 2'd0,
        SEL_B    = 2'd1,
        SEL_C    = 2'd2,
        SEL_DROP = 2'd3
    } sel_e;

    // One-hot slot enable; the drop code maps to no slot at all.
    function automatic logic [NUM_SLOTS-1:0] sel_onehot(input sel_e s);
        logic [NUM_SLOTS-1:0] oh;
        oh = '0;
        case (s)
            SEL_A:   oh = 3'b001;
            SEL_B:   oh = 3'b010;
            SEL_C:   oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/out_slot.sv
// Single-entry output register with load/consume handshake and flush.
module out_slot #(
    parameter int WIDTH = 9
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             consume,
    input  logic             flush,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             can_accept
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Load wins over consume so a same-cycle refill never produces a bubble.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= load_data;
            r_valid <= 1'b1;
        end else if (r_valid && consume) begin
            r_valid <= 1'b0;
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign can_accept = !r_valid || consume;

endmodule

// File: rtl/demux9bit_1to3_reg.sv
// Registered 1-to-3 demux: steers a control word into one of three slots or drops it.
module demux9bit_1to3_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data_a,
    output logic [WIDTH-1:0] out_data_b,
    output logic [WIDTH-1:0] out_data_c,
    output logic             out_valid_a,
    output logic             out_valid_b,
    output logic             out_valid_c,
    input  logic             out_ready_a,
    input  logic             out_ready_b,
    input  logic             out_ready_c,
    output logic [CNT_W-1:0] drop_count
);

    sel_e                 w_sel;
    logic [NUM_SLOTS-1:0] w_sel_oh;
    logic [NUM_SLOTS-1:0] w_out_ready;
    logic [NUM_SLOTS-1:0] w_can_accept;
    logic [NUM_SLOTS-1:0] w_slot_valid;
    logic [WIDTH-1:0]     w_slot_data [NUM_SLOTS];
    logic                 w_in_ready;
    logic                 w_xfer;
    logic [CNT_W-1:0]     r_drop_count;

    assign w_sel       = sel_e'(sel);
    assign w_sel_oh    = sel_onehot(w_sel);
    assign w_out_ready = {out_ready_c, out_ready_b, out_ready_a};

    // Ready depends only on the addressed slot, never on in_valid.
    always_comb begin
        w_in_ready = 1'b0;
        if (!flush) begin
            case (w_sel)
                SEL_A:    w_in_ready = w_can_accept[0];
                SEL_B:    w_in_ready = w_can_accept[1];
                SEL_C:    w_in_ready = w_can_accept[2];
                default:  w_in_ready = 1'b1;
            endcase
        end
    end

    assign w_xfer = in_valid && w_in_ready;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            out_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .Clk        (Clk),
                .Reset      (Reset),
                .load       (w_xfer && w_sel_oh[gi]),
                .load_data  (in_data),
                .consume    (w_out_ready[gi]),
                .flush      (flush),
                .data       (w_slot_data[gi]),
                .valid      (w_slot_valid[gi]),
                .can_accept (w_can_accept[gi])
            );
        end
    endgenerate

    // Saturating count of words discarded through the drop code.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_drop_count <= '0;
        end else if (!flush && w_xfer && (w_sel == SEL_DROP) && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end

    assign in_ready    = w_in_ready;
    assign out_data_a  = w_slot_data[0];
    assign out_data_b  = w_slot_data[1];
    assign out_data_c  = w_slot_data[2];
    assign out_valid_a = w_slot_valid[0];
    assign out_valid_b = w_slot_valid[1];
    assign out_valid_c = w_slot_valid[2];
    assign drop_count  = r_drop_count;

endmodule
